// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with zero-latency hits and a pipelined line refill.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_COUNTERS_EN.
module icache #(
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        miss_o,
  output logic [31:0] rd_data_o,
  output logic        mem_req_valid_o,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_req_ready_i,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);

  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned IdxW = $clog2(NUM_LINES);
  localparam int unsigned TagW = 30 - OffW - IdxW;
  localparam int unsigned CntW = OffW + 1;

  typedef enum logic [0:0] {StIdle, StRefill} state_e;

  logic [OffW-1:0] off;
  logic [IdxW-1:0] idx;
  logic [TagW-1:0] tag;
  logic            unused_addr;

  assign off         = req_addr_i[OffW+1:2];
  assign idx         = req_addr_i[OffW+IdxW+1:OffW+2];
  assign tag         = req_addr_i[31:OffW+IdxW+2];
  assign unused_addr = ^req_addr_i[1:0];

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TagW-1:0]      tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

  state_e          state_q, state_d;
  logic [IdxW-1:0] ref_idx_q, ref_idx_d;
  logic [TagW-1:0] ref_tag_q, ref_tag_d;
  logic [CntW-1:0] req_cnt_q, req_cnt_d;
  logic [CntW-1:0] rsp_cnt_q, rsp_cnt_d;
  logic            flush_pend_q, flush_pend_d;

  logic                 hit, rsp_fire, rsp_last, start_refill;
  logic [IdxW+OffW-1:0] rd_ptr, wr_ptr;

  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_ptr    = {idx, off};
  assign rd_data_o = data_q[rd_ptr];

  // Responses past the last expected beat, or outside a refill, are dropped.
  assign rsp_fire = (state_q == StRefill) && mem_rsp_valid_i &&
                    (rsp_cnt_q < CntW'(LINE_WORDS));
  assign rsp_last = rsp_fire && (rsp_cnt_q == CntW'(LINE_WORDS - 1));
  assign wr_ptr   = {ref_idx_q, rsp_cnt_q[OffW-1:0]};

  assign mem_req_valid_o = (state_q == StRefill) && (req_cnt_q < CntW'(LINE_WORDS));
  assign mem_req_addr_o  = {ref_tag_q, ref_idx_q, req_cnt_q[OffW-1:0], 2'b00};

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    ref_idx_d    = ref_idx_q;
    ref_tag_d    = ref_tag_q;
    req_cnt_d    = req_cnt_q;
    rsp_cnt_d    = rsp_cnt_q;
    flush_pend_d = flush_pend_q;
    ready_o      = 1'b0;
    miss_o       = 1'b0;
    start_refill = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (hit && !flush_i) begin
            ready_o = 1'b1;
          end else begin
            miss_o = 1'b1;
          end
          if (!hit && !flush_i) begin
            start_refill   = 1'b1;
            state_d        = StRefill;
            ref_idx_d      = idx;
            ref_tag_d      = tag;
            valid_d[idx]   = 1'b0;
            req_cnt_d      = '0;
            rsp_cnt_d      = '0;
          end
        end
        if (flush_i) begin
          valid_d = '0;
        end
      end
      StRefill: begin
        miss_o = req_valid_i;
        if (flush_i) begin
          flush_pend_d = 1'b1;
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
          req_cnt_d = req_cnt_q + CntW'(1);
        end
        if (rsp_fire) begin
          rsp_cnt_d = rsp_cnt_q + CntW'(1);
        end
        if (rsp_last) begin
          state_d      = StIdle;
          flush_pend_d = 1'b0;
          // A flush seen at any point during the refill discards the new line too.
          if (flush_pend_q || flush_i) begin
            valid_d = '0;
          end else begin
            valid_d[ref_idx_q] = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      ref_idx_q    <= '0;
      ref_tag_q    <= '0;
      req_cnt_q    <= '0;
      rsp_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      ref_idx_q    <= ref_idx_d;
      ref_tag_q    <= ref_tag_d;
      req_cnt_q    <= req_cnt_d;
      rsp_cnt_q    <= rsp_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rsp_fire) begin
      data_q[wr_ptr] <= mem_rsp_data_i;
    end
    if (rsp_last) begin
      tag_q[ref_idx_q] <= ref_tag_q;
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ready_o && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (start_refill && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  logic unused_start_refill;
  assign unused_start_refill = start_refill;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (default geometry: 64 lines x 4 words).
// Define ICACHE_PERF_COUNTERS_EN to also exercise the hit/miss counters.
module tb_icache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        ready, miss;
  logic [31:0] rd_data;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icache dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .req_valid_i     (req_valid),
    .req_addr_i      (req_addr),
    .flush_i         (flush),
    .ready_o         (ready),
    .miss_o          (miss),
    .rd_data_o       (rd_data),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_ready_i (mem_req_ready),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_data_i  (mem_rsp_data)
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    .hit_count_o     (hit_count),
    .miss_count_o    (miss_count)
`endif
  );

  // Memory content model: each word is its own address xor a fixed pattern.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full refill of addr's line; flush_k >= 0 pulses flush_i on that refill cycle.
  task automatic do_refill(input logic [31:0] addr, input int flush_k);
    logic [31:0] base;
    base = {addr[31:4], 4'h0};
    req_valid = 1'b1; req_addr = addr; flush = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    #1;
    n_cmp++;
    if (miss !== 1'b1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL refill_start %h: miss=%b ready=%b want miss=1 ready=0", addr, miss, ready);
    end
    tick();
    for (int k = 0; k <= 4; k++) begin
      mem_req_ready = 1'b1;
      mem_rsp_valid = (k > 0);
      mem_rsp_data  = (k > 0) ? word_of(base + 32'(4 * (k - 1))) : 32'h0;
      flush         = (k == flush_k);
      #1;
      n_cmp++;
      if (k < 4) begin
        if (mem_req_valid !== 1'b1 || mem_req_addr !== base + 32'(4 * k)) begin
          n_bad++;
          $display("FAIL refill_beat%0d: valid=%b addr=%h want valid=1 addr=%h", k,
                   mem_req_valid, mem_req_addr, base + 32'(4 * k));
        end
      end else if (mem_req_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL refill_done_req: valid=%b want 0", mem_req_valid);
      end
      n_cmp++;
      if (miss !== 1'b1 || ready !== 1'b0) begin
        n_bad++;
        $display("FAIL refill_miss%0d: miss=%b ready=%b want miss=1 ready=0", k, miss, ready);
      end
      tick();
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; flush = 1'b0;
    #1;
    n_cmp++;
    if (flush_k < 0) begin
      if (ready !== 1'b1 || miss !== 1'b0 || rd_data !== word_of(addr)) begin
        n_bad++;
        $display("FAIL refill_hit %h: ready=%b miss=%b data=%h want 1 0 %h", addr, ready, miss,
                 rd_data, word_of(addr));
      end
    end else if (ready !== 1'b0 || miss !== 1'b1) begin
      n_bad++;
      $display("FAIL refill_flushed %h: ready=%b miss=%b want 0 1", addr, ready, miss);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++;
    if (ready !== 1'b0 || miss !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b miss=%b mreq=%b want 0 0 0", ready, miss, mem_req_valid);
    end
    reset = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || miss !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_cold_miss: ready=%b miss=%b want 0 1", ready, miss);
    end
    req_valid = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || miss !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_noreq: ready=%b miss=%b want 0 0", ready, miss);
    end
    tick();
  endtask

  task automatic test_refill();
    do_refill(32'h100, -1);
    req_addr = 32'h10C;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || rd_data !== 32'hC0DE_010C) begin
      n_bad++;
      $display("FAIL hit_word3: ready=%b data=%h want 1 c0de010c", ready, rd_data);
    end
    req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
    tick();
    mem_rsp_valid = 1'b0; req_valid = 1'b1; req_addr = 32'h104;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || rd_data !== 32'hC0DE_0104) begin
      n_bad++;
      $display("FAIL idle_rsp_ignored: ready=%b data=%h want 1 c0de0104", ready, rd_data);
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    req_valid = 1'b1; req_addr = 32'h300; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    #1;
    tick();
    for (int k = 0; k < 7; k++) begin
      logic [31:0] exp_addr;
      mem_req_ready = !(k >= 2 && k <= 4);
      exp_addr = 32'h300 + 32'(4 * ((k < 2) ? k : ((k <= 4) ? 2 : k - 3)));
      if (k >= 2) req_addr = 32'h700;
      #1;
      n_cmp++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr || miss !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_beat%0d: valid=%b addr=%h miss=%b want 1 %h 1", k, mem_req_valid,
                 mem_req_addr, miss, exp_addr);
      end
      tick();
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = word_of(32'h300 + 32'(4 * i));
      if (i == 3) req_addr = 32'h30C;
      #1;
      n_cmp++;
      if (mem_req_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_all_issued%0d: valid=%b want 0", i, mem_req_valid);
      end
      tick();
    end
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || rd_data !== 32'hC0DE_030C) begin
      n_bad++;
      $display("FAIL stall_hit: ready=%b data=%h want 1 c0de030c", ready, rd_data);
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_conflict();
    req_valid = 1'b1; req_addr = 32'h100;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || rd_data !== 32'hC0DE_0100) begin
      n_bad++;
      $display("FAIL conflict_pre_hit: ready=%b data=%h want 1 c0de0100", ready, rd_data);
    end
    do_refill(32'h1100, -1);
    req_addr = 32'h100;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || miss !== 1'b1) begin
      n_bad++;
      $display("FAIL conflict_evicted: ready=%b miss=%b want 0 1", ready, miss);
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_refill();
    do_refill(32'h200, 2);
    req_addr = 32'h1100;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || miss !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_refill_old1: ready=%b miss=%b want 0 1", ready, miss);
    end
    req_addr = 32'h300;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || miss !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_refill_old2: ready=%b miss=%b want 0 1", ready, miss);
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush_idle();
    do_refill(32'h100, -1);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || miss !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_idle_cycle: ready=%b miss=%b want 0 1", ready, miss);
    end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || miss !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_idle_after: ready=%b miss=%b mreq=%b want 0 1 0", ready, miss,
               mem_req_valid);
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_addr = 32'h100;
    #1;
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_req_ready = 1'b1;
      mem_rsp_valid = (k > 0);
      mem_rsp_data  = 32'hDEAD_0000 + 32'(k);
      #1;
      tick();
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; req_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_req_valid !== 1'b0 || miss !== 1'b0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: mreq=%b miss=%b ready=%b want 0 0 0", mem_req_valid, miss, ready);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
      tick();
    end
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_stray: mreq=%b want 0", mem_req_valid);
    end
    do_refill(32'h100, -1);
    req_valid = 1'b0;
    tick();
  endtask

`ifdef ICACHE_PERF_COUNTERS_EN
  task automatic test_perf();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_reset: hit=%0d miss=%0d want 0 0", hit_count, miss_count);
    end
    tick();
    reset = 1'b0;
    do_refill(32'h100, -1);
    tick(); tick(); tick();
    req_valid = 1'b0;
    #1;
    n_cmp++;
    if (hit_count !== 32'd3 || miss_count !== 32'd1) begin
      n_bad++;
      $display("FAIL perf_counts: hit=%0d miss=%0d want 3 1", hit_count, miss_count);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_refill();
    test_stall();
    test_conflict();
    test_flush_refill();
    test_flush_idle();
    test_reset_mid();
`ifdef ICACHE_PERF_COUNTERS_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
